// File: rtl/player_pkg.sv
// Shared encodings and default tuning constants for the player action FSM.
package player_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WALK_L   = 3'd1,
        WALK_R   = 3'd2,
        CROUCH   = 3'd3,
        JUMP     = 3'd4,
        ATTACK   = 3'd5,
        SHIELD   = 3'd6,
        COOLDOWN = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        MV_CENTER = 3'd0,
        MV_LEFT   = 3'd1,
        MV_RIGHT  = 3'd2,
        MV_UP     = 3'd3,
        MV_DOWN   = 3'd4
    } move_t;

    localparam int CI_CENTER = 0;
    localparam int CI_LEFT   = 1;
    localparam int CI_RIGHT  = 2;
    localparam int CI_UP     = 3;
    localparam int CI_DOWN   = 4;
    localparam int CI_ATTACK = 5;
    localparam int CI_SHIELD = 6;

    localparam logic [9:0] X_MIN_DEF           = 10'd0;
    localparam logic [9:0] X_MAX_DEF           = 10'd600;
    localparam logic [9:0] X_START_DEF         = 10'd100;
    localparam logic [3:0] WALK_STEP_DEF       = 4'd2;
    localparam logic [5:0] JUMP_VEL_DEF        = 6'd12;
    localparam logic [5:0] GRAVITY_DEF         = 6'd1;
    localparam logic [5:0] ATTACK_FRAMES_DEF   = 6'd12;
    localparam logic [5:0] COOLDOWN_FRAMES_DEF = 6'd20;

    // Anything other than exactly one movement bit collapses to center.
    function automatic move_t decode_move(input logic [6:0] ci);
        logic [4:0] v;
        v = ci[4:0];
        if (v == 5'd0 || (v & (v - 5'd1)) != 5'd0) return MV_CENTER;
        if (v[CI_LEFT])  return MV_LEFT;
        if (v[CI_RIGHT]) return MV_RIGHT;
        if (v[CI_UP])    return MV_UP;
        if (v[CI_DOWN])  return MV_DOWN;
        return MV_CENTER;
    endfunction

endpackage

// File: rtl/frame_counter.sv
// Tick-enabled loadable down-counter; done while the count sits at zero.
module frame_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en) begin
            if (load) begin
                cnt_q <= load_val;
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - ONE;
            end
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/player_action_fsm.sv
// Per-frame player action state machine: position, jump arc, attack/shield flags.
module player_action_fsm
    import player_pkg::*;
#(
    parameter logic [9:0] X_MIN           = X_MIN_DEF,
    parameter logic [9:0] X_MAX           = X_MAX_DEF,
    parameter logic [9:0] X_START         = X_START_DEF,
    parameter logic [3:0] WALK_STEP       = WALK_STEP_DEF,
    parameter logic [5:0] JUMP_VEL        = JUMP_VEL_DEF,
    parameter logic [5:0] GRAVITY         = GRAVITY_DEF,
    parameter logic [5:0] ATTACK_FRAMES   = ATTACK_FRAMES_DEF,
    parameter logic [5:0] COOLDOWN_FRAMES = COOLDOWN_FRAMES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [6:0] controller_inputs,
    output logic [2:0] action_state,
    output logic [9:0] x_pos,
    output logic [7:0] y_offset,
    output logic       attack_active,
    output logic       shield_active
);

    state_t            state_q, state_d;
    logic [9:0]        x_q, x_d;
    logic [7:0]        y_q, y_d;
    logic signed [6:0] vy_q, vy_d;
    logic              atk_q, atk_d;
    logic              shd_q, shd_d;
    logic              cnt_load;
    logic [5:0]        cnt_load_val;
    logic              cnt_done;
    move_t             mv;
    logic signed [8:0] y_next;

    // 11-bit intermediate so a step past either edge clamps instead of wrapping.
    function automatic logic [9:0] step_x(input logic [9:0] x, input logic go_left);
        logic [10:0] s;
        if (go_left) begin
            s = {1'b0, x} - {7'd0, WALK_STEP};
            if (s[10] || s < {1'b0, X_MIN}) return X_MIN;
        end else begin
            s = {1'b0, x} + {7'd0, WALK_STEP};
            if (s > {1'b0, X_MAX}) return X_MAX;
        end
        return s[9:0];
    endfunction

    assign mv     = decode_move(controller_inputs);
    assign y_next = $signed({1'b0, y_q}) + $signed({{2{vy_q[6]}}, vy_q});

    frame_counter #(.W(6)) u_frame_counter (
        .clk      (clk),
        .reset    (reset),
        .en       (tick),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .done     (cnt_done)
    );

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        vy_d         = vy_q;
        cnt_load     = 1'b0;
        cnt_load_val = ATTACK_FRAMES - 6'd1;
        if (tick) begin
            case (state_q)
                IDLE, WALK_L, WALK_R, CROUCH: begin
                    if (controller_inputs[CI_ATTACK]) begin
                        state_d  = ATTACK;
                        cnt_load = 1'b1;
                    end else if (controller_inputs[CI_SHIELD]) begin
                        state_d = SHIELD;
                    end else begin
                        case (mv)
                            MV_UP: begin
                                state_d = JUMP;
                                vy_d    = $signed({1'b0, JUMP_VEL});
                            end
                            MV_DOWN:  state_d = CROUCH;
                            MV_LEFT: begin
                                state_d = WALK_L;
                                x_d     = step_x(x_q, 1'b1);
                            end
                            MV_RIGHT: begin
                                state_d = WALK_R;
                                x_d     = step_x(x_q, 1'b0);
                            end
                            default:  state_d = IDLE;
                        endcase
                    end
                end
                JUMP: begin
                    if (y_next <= 9'sd0) begin
                        y_d     = 8'd0;
                        vy_d    = 7'sd0;
                        state_d = IDLE;
                    end else begin
                        y_d  = y_next[7:0];
                        vy_d = vy_q - $signed({1'b0, GRAVITY});
                    end
                    if (mv == MV_LEFT)  x_d = step_x(x_q, 1'b1);
                    if (mv == MV_RIGHT) x_d = step_x(x_q, 1'b0);
                end
                ATTACK: begin
                    if (cnt_done) begin
                        state_d      = COOLDOWN;
                        cnt_load     = 1'b1;
                        cnt_load_val = COOLDOWN_FRAMES - 6'd1;
                    end
                end
                COOLDOWN: begin
                    if (cnt_done) state_d = IDLE;
                end
                SHIELD: begin
                    if (!controller_inputs[CI_SHIELD]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        atk_d = (state_d == ATTACK);
        shd_d = (state_d == SHIELD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= X_START;
            y_q     <= 8'd0;
            vy_q    <= 7'sd0;
            atk_q   <= 1'b0;
            shd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            vy_q    <= vy_d;
            atk_q   <= atk_d;
            shd_q   <= shd_d;
        end
    end

    assign action_state  = state_q;
    assign x_pos         = x_q;
    assign y_offset      = y_q;
    assign attack_active = atk_q;
    assign shield_active = shd_q;

endmodule
